// File: rtl/ingress_queue_bridge_if.sv
// rtl/ingress_queue_bridge_if.sv - channel/consumer signal bundle for the ingress queue bridge

interface ingress_queue_bridge_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Source side: one word and one ready/ack pair per channel
  logic [CHANNELS*WIDTH-1:0] ch_data_in;
  logic [CHANNELS-1:0]       ch_ready_in;
  logic [CHANNELS-1:0]       ch_ack_out;

  // Consumer side: show-ahead head word, pop strobe and status
  logic                      dequeue_in;
  logic [WIDTH-1:0]          data_out;
  logic [LW-1:0]             len_out;
  logic                      empty_out;
  logic                      full_out;
  logic                      almost_full_out;
  logic                      underflow_out;
  logic [GW-1:0]             last_grant_out;

  // Environment view: drives channels and pops, observes the queue
  modport master (
    output ch_data_in, ch_ready_in, dequeue_in,
    input  ch_ack_out, data_out, len_out, empty_out, full_out,
           almost_full_out, underflow_out, last_grant_out
  );

  // Bridge view
  modport slave (
    input  ch_data_in, ch_ready_in, dequeue_in,
    output ch_ack_out, data_out, len_out, empty_out, full_out,
           almost_full_out, underflow_out, last_grant_out
  );

endinterface

// File: rtl/ingress_queue_bridge.sv
// rtl/ingress_queue_bridge.sv - round-robin multi-channel enqueue into a show-ahead word FIFO

module ingress_queue_bridge #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 2,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                 clk_10KHz,
  input  logic                 reset,
  ingress_queue_bridge_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L       = LW'(AF_LEVEL);
  localparam logic [GW:0]   CHANNELS_L = (GW + 1)'(CHANNELS);
  localparam logic [GW-1:0] LAST_CH    = GW'(CHANNELS - 1);

  // Queue storage (never reset) and its bookkeeping
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       count;

  // Arbitration state and registered handshake/status
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       last_grant;
  logic [CHANNELS-1:0] ack;
  logic                underflow;

  // Per-cycle decode
  logic [WIDTH-1:0]    ch_word [CHANNELS];
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] ack_next;
  logic [GW:0]         scan_sum;
  logic [GW-1:0]       scan_idx;
  logic [GW-1:0]       win;
  logic [GW-1:0]       rr_next;
  logic                found;
  logic                grant;
  logic                pop;
  logic                is_empty;

  // Split the packed channel bus into one word per channel
  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign ch_word[g] = bus.ch_data_in[g*WIDTH +: WIDTH];
  end

  // A channel that is being acked this cycle is masked so a source still
  // holding ready through its ack cycle is not enqueued a second time.
  assign eligible = bus.ch_ready_in & ~ack;

  // Round-robin search: first eligible channel at or after rr_ptr, wrapping
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      scan_sum = {1'b0, rr_ptr} + (GW + 1)'(i);
      if (scan_sum >= CHANNELS_L) begin
        scan_sum = scan_sum - CHANNELS_L;
      end
      scan_idx = scan_sum[GW-1:0];
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // Space is judged on the registered count only; a same-edge pop does not
  // free a slot for a grant on that edge.
  assign grant    = found && (count < DEPTH_L);
  assign is_empty = (count == '0);
  assign pop      = bus.dequeue_in && !is_empty;
  assign rr_next  = (win == LAST_CH) ? '0 : win + 1'b1;

  // One-hot acknowledge for the winner, all other bits low
  always_comb begin
    ack_next = '0;
    if (grant) begin
      ack_next[win] = 1'b1;
    end
  end

  // Pointers, occupancy, arbitration pointer and sticky underflow
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      last_grant <= '0;
      ack        <= '0;
      underflow  <= 1'b0;
    end else begin
      ack <= ack_next;
      if (grant) begin
        wr_ptr     <= wr_ptr + 1'b1;
        rr_ptr     <= rr_next;
        last_grant <= win;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.dequeue_in && is_empty) begin
        underflow <= 1'b1;
      end
      if (grant && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !grant) begin
        count <= count - 1'b1;
      end
    end
  end

  // Word storage; contents are don't-care until written after reset
  always_ff @(posedge clk_10KHz) begin
    if (grant && !reset) begin
      mem[wr_ptr] <= ch_word[win];
    end
  end

  assign bus.ch_ack_out      = ack;
  assign bus.len_out         = count;
  assign bus.empty_out       = is_empty;
  assign bus.full_out        = (count == DEPTH_L);
  assign bus.almost_full_out = (count >= AF_L);
  assign bus.underflow_out   = underflow;
  assign bus.last_grant_out  = last_grant;
  assign bus.data_out        = is_empty ? '0 : mem[rd_ptr];

endmodule
